// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and instruction memory.
// master: sequencer side; slave: memory side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output instr
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, fetches over a req/ack bus, holds instructions for decode, applies
// branch/jump/jr redirects. Define PC_ALIGN_CHECK_EN to trap misaligned jr targets to TRAP_PC.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pc_sequencer_if.master        imem,
  output logic                  instr_valid_o,
  output logic [31:0]           instr_o,
  output logic [31:0]           pc_o,
  output logic [31:0]           pc_plus4_o,
  input  logic                  stall_i,
  input  logic                  br_taken_i,
  input  logic [15:0]           br_imm_i,
  input  logic                  jmp_i,
  input  logic [25:0]           jmp_idx_i,
  input  logic                  jr_i,
  input  logic [31:0]           jr_addr_i,
  output logic                  trap_o
);

  typedef enum logic [1:0] {StBoot, StReq, StIssue} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] held_pc_q, held_pc_d;

  logic        redirect;
  logic        trap;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] target;

  assign pc_plus4_o = held_pc_q + 32'd4;
  assign br_tgt     = pc_plus4_o + {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
  assign jmp_tgt    = {pc_plus4_o[31:28], jmp_idx_i, 2'b00};
  assign redirect   = br_taken_i | jmp_i | jr_i;

`ifdef PC_ALIGN_CHECK_EN
  logic jr_misaligned;
  assign jr_misaligned = |jr_addr_i[1:0];
  assign jr_tgt        = jr_misaligned ? TRAP_PC : jr_addr_i;
`else
  logic jr_misaligned;
  logic unused_align;
  assign jr_misaligned = 1'b0;
  assign jr_tgt        = {jr_addr_i[31:2], 2'b00};
  assign unused_align  = ^{TRAP_PC, jr_addr_i[1:0]};
`endif

  always_comb begin
    target = br_tgt;
    if (jr_i) begin
      target = jr_tgt;
    end else if (jmp_i) begin
      target = jmp_tgt;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    held_pc_d = held_pc_q;
    trap      = 1'b0;
    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (imem.imem_ack) begin
          instr_d   = imem.instr;
          held_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        // A redirect overrides stall: the held instruction is being discarded anyway.
        if (redirect) begin
          pc_d    = target;
          trap    = jr_i & jr_misaligned;
          state_d = StReq;
        end else if (!stall_i) begin
          state_d = StReq;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      held_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      held_pc_q <= held_pc_d;
    end
  end

  assign imem.imem_req  = (state_q == StReq);
  assign imem.imem_addr = pc_q;
  assign instr_valid_o  = (state_q == StIssue);
  assign instr_o        = instr_q;
  assign pc_o           = held_pc_q;
  assign trap_o         = trap & ~rst_i;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expected values are hand-computed.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jmp;
  logic [25:0] jmp_idx;
  logic        jr;
  logic [31:0] jr_addr;
  logic        trap;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem          (bus),
    .instr_valid_o (instr_valid),
    .instr_o       (instr_out),
    .pc_o          (pc_out),
    .pc_plus4_o    (pc_plus4),
    .stall_i       (stall),
    .br_taken_i    (br_taken),
    .br_imm_i      (br_imm),
    .jmp_i         (jmp),
    .jmp_idx_i     (jmp_idx),
    .jr_i          (jr),
    .jr_addr_i     (jr_addr),
    .trap_o        (trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one instruction in REQ and land in ISSUE.
  task automatic ack_fetch(input logic [31:0] word);
    bus.imem_ack = 1'b1;
    bus.instr    = word;
    tick();
    bus.imem_ack = 1'b0;
  endtask

  // Redirect via jr from ISSUE, then fetch so the held pc equals addr.
  task automatic land_at(input logic [31:0] addr, input logic [31:0] word);
    jr = 1'b1;
    jr_addr = addr;
    tick();
    jr = 1'b0;
    ack_fetch(word);
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 1'b0;
    br_taken     = 1'b0;
    br_imm       = 16'h0;
    jmp          = 1'b0;
    jmp_idx      = 26'h0;
    jr           = 1'b0;
    jr_addr      = 32'h0;
    bus.imem_ack = 1'b0;
    bus.instr    = 32'h0;
    repeat (3) tick();

    check_eq("rst_req",   {31'b0, bus.imem_req}, 32'h0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("rst_instr", instr_out, 32'h0);
    check_eq("rst_pc",    pc_out, 32'h0);
    check_eq("rst_addr",  bus.imem_addr, 32'h0);
    check_eq("rst_trap",  {31'b0, trap}, 32'h0);

    // Reset release: BOOT for one cycle, then request at RESET_PC.
    rst = 1'b0;
    tick();
    check_eq("first_req",  {31'b0, bus.imem_req}, 32'h1);
    check_eq("first_addr", bus.imem_addr, 32'h0);

    ack_fetch(32'h2001_0005);
    check_eq("first_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("first_instr", instr_out, 32'h2001_0005);
    check_eq("first_pc",    pc_out, 32'h0);
    check_eq("first_pc4",   pc_plus4, 32'h4);
    check_eq("issue_noreq", {31'b0, bus.imem_req}, 32'h0);

    tick();
    check_eq("next_addr",  bus.imem_addr, 32'h4);
    check_eq("next_valid", {31'b0, instr_valid}, 32'h0);

    // Memory wait of three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wait_req",   {31'b0, bus.imem_req}, 32'h1);
      check_eq("wait_addr",  bus.imem_addr, 32'h4);
      check_eq("wait_valid", {31'b0, instr_valid}, 32'h0);
    end
    ack_fetch(32'h1111_2222);
    check_eq("wait_pc", pc_out, 32'h4);

    // Backward branch from 0x10: 0x14 + (-4 << 2) = 0x4.
    land_at(32'h0000_0010, 32'h3333_4444);
    check_eq("br_setup_pc", pc_out, 32'h10);
    // Ack outside REQ is ignored.
    stall = 1'b1;
    bus.imem_ack = 1'b1;
    bus.instr    = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    stall = 1'b0;
    check_eq("ack_ignored", instr_out, 32'h3333_4444);
    br_taken = 1'b1;
    br_imm   = 16'hFFFC;
    tick();
    br_taken = 1'b0;
    check_eq("br_addr",  bus.imem_addr, 32'h4);
    check_eq("br_req",   {31'b0, bus.imem_req}, 32'h1);
    check_eq("br_valid", {31'b0, instr_valid}, 32'h0);
    ack_fetch(32'h5555_6666);

    // Jump wins over branch: {0x1, 0x40, 00} = 0x1000_0100.
    land_at(32'h1000_0000, 32'h7777_8888);
    jmp      = 1'b1;
    br_taken = 1'b1;
    br_imm   = 16'h0010;
    jmp_idx  = 26'h000_0040;
    tick();
    jmp      = 1'b0;
    br_taken = 1'b0;
    check_eq("jmp_addr", bus.imem_addr, 32'h1000_0100);

    // Stall holds everything; jr with stall still redirects.
    ack_fetch(32'hAAAA_5555);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("stall_instr", instr_out, 32'hAAAA_5555);
      check_eq("stall_pc",    pc_out, 32'h1000_0100);
      check_eq("stall_req",   {31'b0, bus.imem_req}, 32'h0);
    end
    jr      = 1'b1;
    jr_addr = 32'h0000_0200;
    tick();
    jr    = 1'b0;
    stall = 1'b0;
    check_eq("jr_stall_addr", bus.imem_addr, 32'h200);
    check_eq("jr_stall_req",  {31'b0, bus.imem_req}, 32'h1);

    // Reset while requesting; a late ack lands in BOOT and is dropped.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.imem_ack = 1'b1;
    bus.instr    = 32'hBAD0_BAD0;
    tick();
    bus.imem_ack = 1'b0;
    check_eq("rstreq_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("rstreq_addr",  bus.imem_addr, 32'h0);
    check_eq("rstreq_req",   {31'b0, bus.imem_req}, 32'h1);

    // Misaligned jr target.
    ack_fetch(32'h0C0C_0C0C);
    jr      = 1'b1;
    jr_addr = 32'h0000_0203;
    #1;
`ifdef PC_ALIGN_CHECK_EN
    check_eq("trap_pulse", {31'b0, trap}, 32'h1);
`else
    check_eq("trap_pulse", {31'b0, trap}, 32'h0);
`endif
    tick();
    jr = 1'b0;
    #1;
`ifdef PC_ALIGN_CHECK_EN
    check_eq("trap_addr", bus.imem_addr, 32'h80);
`else
    check_eq("trap_addr", bus.imem_addr, 32'h200);
`endif
    check_eq("trap_clear", {31'b0, trap}, 32'h0);
    ack_fetch(32'h0101_0101);

    // PC wraps from 0xFFFF_FFFC to 0.
    land_at(32'hFFFF_FFFC, 32'h0F0F_0F0F);
    check_eq("wrap_pc4", pc_plus4, 32'h0);
    tick();
    check_eq("wrap_addr", bus.imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
